// File: rtl/cool_heat_controller_pkg.sv
// Shared types and default settings for the cool/heat climate controller.
package cool_heat_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEATING = 2'd1,
      COOLING = 2'd2,
      ST_RSVD = 2'd3
   } state_e;

   localparam logic [7:0] T_HEAT_ON_DEF  = 8'd15;
   localparam logic [7:0] T_HEAT_OFF_DEF = 8'd20;
   localparam logic [7:0] T_COOL_OFF_DEF = 8'd25;
   localparam logic [7:0] T_COOL_ON_DEF  = 8'd35;
   localparam logic [7:0] HOT_DELTA_DEF  = 8'd10;
   localparam logic [3:0] MIN_DWELL_DEF  = 4'd4;

   localparam logic [3:0] OCC_MAX      = 4'd8;
   localparam logic [3:0] OCC_FAN_STEP = 4'd4;

   // Fan steps can add up past the 2-bit range; clamp rather than wrap.
   function automatic logic [1:0] fan_sat(input logic [2:0] steps);
      return (steps > 3'd3) ? 2'd3 : steps[1:0];
   endfunction

endpackage

// File: rtl/cool_heat_controller_if.sv
// Sample input / actuator output bundle of the climate controller.
interface cool_heat_if;
   logic       sample_valid;
   logic [7:0] temperature;
   logic [3:0] occupancy;
   logic       heater_on;
   logic       cooler_on;
   logic [1:0] fan_speed;
   logic [1:0] state;

   modport master (
      output sample_valid, temperature, occupancy,
      input  heater_on, cooler_on, fan_speed, state
   );

   modport slave (
      input  sample_valid, temperature, occupancy,
      output heater_on, cooler_on, fan_speed, state
   );
endinterface

// File: rtl/cool_heat_controller_dwell_timer.sv
// Saturating dwell counter; expired means the coming edge completes MIN_DWELL
// cycles in the current state.
module dwell_timer #(
   parameter logic [3:0] MIN_DWELL = 4'd4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic expired
);

   logic [3:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = 4'd0;
      else if (count_q < MIN_DWELL)
         count_d = count_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         count_q <= 4'd0;
      else
         count_q <= count_d;
   end

   assign expired = ({1'b0, count_q} + 5'd1) >= {1'b0, MIN_DWELL};

endmodule

// File: rtl/cool_heat_controller.sv
// Heater/cooler/fan sequencer with hysteresis and minimum dwell; all outputs
// registered and decoded from the next state.
module cool_heat_controller
   import cool_heat_pkg::*;
#(
   parameter logic [7:0] T_HEAT_ON  = T_HEAT_ON_DEF,
   parameter logic [7:0] T_HEAT_OFF = T_HEAT_OFF_DEF,
   parameter logic [7:0] T_COOL_OFF = T_COOL_OFF_DEF,
   parameter logic [7:0] T_COOL_ON  = T_COOL_ON_DEF,
   parameter logic [7:0] HOT_DELTA  = HOT_DELTA_DEF,
   parameter logic [3:0] MIN_DWELL  = MIN_DWELL_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   cool_heat_if.slave  bus
);

   // state   | meaning
   // IDLE    | both actuators off, fan off
   // HEATING | heater on, fan 1..2 by occupancy
   // COOLING | cooler on, fan 1..3 by heat excess and occupancy
   // ST_RSVD | unreachable; forced back to IDLE

   localparam logic [8:0] T_HOT = {1'b0, T_COOL_ON} + {1'b0, HOT_DELTA};

   state_e     state_q, state_d;
   logic       heater_q, heater_d;
   logic       cooler_q, cooler_d;
   logic [1:0] fan_q, fan_d;
   logic       dwell_clear;
   logic       dwell_expired;
   logic [3:0] occ_sat;
   logic       occ_step;
   logic       hot_step;

   assign occ_sat  = (bus.occupancy > OCC_MAX) ? OCC_MAX : bus.occupancy;
   assign occ_step = (occ_sat >= OCC_FAN_STEP);
   assign hot_step = ({1'b0, bus.temperature} >= T_HOT);

   dwell_timer #(.MIN_DWELL(MIN_DWELL)) u_dwell (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (dwell_clear),
      .expired (dwell_expired)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.sample_valid) begin
               if (bus.temperature < T_HEAT_ON)
                  state_d = HEATING;
               else if (bus.temperature > T_COOL_ON)
                  state_d = COOLING;
            end
         end
         HEATING: begin
            if (bus.sample_valid && (bus.temperature >= T_HEAT_OFF) && dwell_expired)
               state_d = IDLE;
         end
         COOLING: begin
            if (bus.sample_valid && (bus.temperature <= T_COOL_OFF) && dwell_expired)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign dwell_clear = (state_d != state_q);

   // Fan tracks valid samples only; an invalid cycle leaves the speed as is.
   always_comb begin
      heater_d = (state_d == HEATING);
      cooler_d = (state_d == COOLING);
      fan_d    = fan_q;
      unique case (state_d)
         HEATING: if (bus.sample_valid) fan_d = fan_sat(3'd1 + {2'b00, occ_step});
         COOLING: if (bus.sample_valid) fan_d = fan_sat(3'd1 + {2'b00, hot_step} + {2'b00, occ_step});
         default: fan_d = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         heater_q <= 1'b0;
         cooler_q <= 1'b0;
         fan_q    <= 2'd0;
      end else begin
         state_q  <= state_d;
         heater_q <= heater_d;
         cooler_q <= cooler_d;
         fan_q    <= fan_d;
      end
   end

   assign bus.state     = state_q;
   assign bus.heater_on = heater_q;
   assign bus.cooler_on = cooler_q;
   assign bus.fan_speed = fan_q;

endmodule

// File: tb/tb_cool_heat_controller.sv
// Directed-vector bench for cool_heat_controller with a queue-based scoreboard.
module tb_cool_heat_controller;
   import cool_heat_pkg::*;

   typedef struct packed {
      logic [1:0] st;
      logic       heat;
      logic       cool;
      logic [1:0] fan;
   } exp_t;

   logic clk;
   logic rst_n;
   cool_heat_if bus();

   exp_t  exp_q[$];
   string name_q[$];
   int    n_checks;
   int    n_fail;

   cool_heat_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      if (!(T_HEAT_ON_DEF < T_HEAT_OFF_DEF && T_HEAT_OFF_DEF <= T_COOL_OFF_DEF &&
            T_COOL_OFF_DEF < T_COOL_ON_DEF)) begin
         $display("FAIL threshold_order: thresholds are not strictly ordered");
         $fatal(1, "illegal thresholds");
      end
   end

   // Drive one cycle of stimulus and queue the response expected after that edge.
   task automatic step(input logic r, input logic v, input logic [7:0] t,
                       input logic [3:0] o, input logic [1:0] es,
                       input logic [1:0] ef, input string nm);
      exp_t e;
      @(negedge clk);
      rst_n            = r;
      bus.sample_valid = v;
      bus.temperature  = t;
      bus.occupancy    = o;
      @(posedge clk);
      e.st   = es;
      e.heat = (es == 2'd1);
      e.cool = (es == 2'd2);
      e.fan  = ef;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t  e;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         n_checks++;
         if ({bus.state, bus.heater_on, bus.cooler_on, bus.fan_speed} !== e) begin
            n_fail++;
            $display("FAIL %s: got state=%0d heat=%0d cool=%0d fan=%0d, want state=%0d heat=%0d cool=%0d fan=%0d",
                     nm, bus.state, bus.heater_on, bus.cooler_on, bus.fan_speed,
                     e.st, e.heat, e.cool, e.fan);
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n            = 1'b0;
      bus.sample_valid = 1'b0;
      bus.temperature  = 8'd0;
      bus.occupancy    = 4'd0;

      step(0, 1, 8'd22, 4'd3, 2'd0, 2'd0, "reset_0");
      step(0, 1, 8'd22, 4'd3, 2'd0, 2'd0, "reset_1");
      step(1, 1, 8'd22, 4'd3, 2'd0, 2'd0, "idle_22");

      step(1, 1, 8'd10, 4'd5, 2'd1, 2'd2, "heat_entry");
      step(1, 1, 8'd21, 4'd5, 2'd1, 2'd2, "heat_dwell_1");
      step(1, 1, 8'd21, 4'd5, 2'd1, 2'd2, "heat_dwell_2");
      step(1, 1, 8'd21, 4'd5, 2'd1, 2'd2, "heat_dwell_3");
      step(1, 1, 8'd21, 4'd5, 2'd0, 2'd0, "heat_exit");

      step(1, 1, 8'd36, 4'd0, 2'd2, 2'd1, "cool_entry");
      step(1, 1, 8'd45, 4'd8, 2'd2, 2'd3, "cool_fan_max");
      step(1, 1, 8'd25, 4'd8, 2'd2, 2'd2, "cool_early_1");
      step(1, 1, 8'd25, 4'd8, 2'd2, 2'd2, "cool_early_2");
      step(1, 1, 8'd25, 4'd8, 2'd0, 2'd0, "cool_exit");

      step(1, 1, 8'd15, 4'd0, 2'd0, 2'd0, "idle_eq_heat_on");
      step(1, 1, 8'd35, 4'd0, 2'd0, 2'd0, "idle_eq_cool_on");
      step(1, 1, 8'd14, 4'd0, 2'd1, 2'd1, "heat_at_14");
      for (int i = 0; i < 3; i++)
         step(1, 1, 8'd20, 4'd0, 2'd1, 2'd1, "heat_hold_20");
      step(1, 1, 8'd20, 4'd0, 2'd0, 2'd0, "heat_exit_eq_off");

      step(1, 1, 8'd40, 4'd2, 2'd2, 2'd1, "cool_at_40");
      for (int i = 0; i < 4; i++)
         step(1, 1, 8'd26, 4'd2, 2'd2, 2'd1, "cool_hold_26");
      step(1, 1, 8'd25, 4'd2, 2'd0, 2'd0, "cool_exit_eq_off");

      for (int i = 0; i < 10; i++)
         step(1, 0, 8'd5, 4'd1, 2'd0, 2'd0, "invalid_hold");
      step(1, 1, 8'd5, 4'd1, 2'd1, 2'd1, "valid_heat");
      for (int i = 0; i < 3; i++)
         step(1, 0, 8'd25, 4'd8, 2'd1, 2'd1, "invalid_dwell");
      step(1, 1, 8'd25, 4'd8, 2'd0, 2'd0, "dwell_ran_invalid");

      step(1, 1, 8'd50, 4'd15, 2'd2, 2'd3, "cool_occ_ovf");
      step(0, 1, 8'd50, 4'd15, 2'd0, 2'd0, "reset_mid_cool");
      step(1, 1, 8'd50, 4'd15, 2'd2, 2'd3, "cool_reentry");
      step(1, 1, 8'd255, 4'd0, 2'd2, 2'd2, "cool_255_1");
      step(1, 1, 8'd255, 4'd0, 2'd2, 2'd2, "cool_255_2");
      step(1, 1, 8'd255, 4'd0, 2'd2, 2'd2, "cool_255_3");
      step(1, 1, 8'd0, 4'd0, 2'd0, 2'd0, "cool_exit_0");
      step(1, 1, 8'd0, 4'd0, 2'd1, 2'd1, "heat_at_0");
      step(1, 1, 8'd0, 4'd4, 2'd1, 2'd2, "heat_occ_4");
      step(0, 1, 8'd0, 4'd4, 2'd0, 2'd0, "reset_mid_heat");

      for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expected responses never compared, want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
